// File: rtl/wb_arbiter.sv
// wb_arbiter: two-source writeback arbiter in front of a register file.
// Source 0 is the ALU writeback, source 1 is the load-unit writeback. A
// granted write is presented to the register file one cycle after its
// handshake; write_register = 0 means "no write this cycle".
// Build option: define WB_ARBITER_FIXED_PRIORITY_EN to make source 1 always
// win contention. Without it, contention is resolved round-robin against
// grant_last.
module wb_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_REGISTERS = 32,
    localparam int INDEX_WIDTH  = $clog2(NUM_REGISTERS)
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [INDEX_WIDTH-1:0] req0_register,
    input  logic [DATA_WIDTH-1:0]  req0_data,

    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [INDEX_WIDTH-1:0] req1_register,
    input  logic [DATA_WIDTH-1:0]  req1_data,

    output logic [INDEX_WIDTH-1:0] write_register,
    output logic [DATA_WIDTH-1:0]  write_data,
    output logic                   grant_last
);

    logic grant0;
    logic grant1;

    // Pick at most one source per cycle; nothing is granted while in reset.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            if (req0_valid && req1_valid) begin
`ifdef WB_ARBITER_FIXED_PRIORITY_EN
                // Loads always win; the ALU result waits.
                grant1 = 1'b1;
`else
                // Round-robin: whoever was not granted last goes now.
                if (grant_last) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
`endif
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    // A grant only ever accompanies a valid, so ready doubles as the transfer flag.
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Register the accepted write for the register file and remember who won.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            write_register <= '0;
            write_data     <= '0;
            grant_last     <= 1'b1;   // makes source 0 win the first contention
        end else if (grant0) begin
            write_register <= req0_register;
            write_data     <= req0_data;
            grant_last     <= 1'b0;
        end else if (grant1) begin
            write_register <= req1_register;
            write_data     <= req1_data;
            grant_last     <= 1'b1;
        end else begin
            // Idle cycle: issue a no-op write, keep the last data on the bus.
            write_register <= '0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed bench for wb_arbiter with a small register-file
// model on the write port. Expectations adapt to the
// WB_ARBITER_FIXED_PRIORITY_EN build option.
module tb_wb_arbiter;

`ifdef WB_ARBITER_FIXED_PRIORITY_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic        req0_ready;
    logic [4:0]  req0_register;
    logic [31:0] req0_data;
    logic        req1_valid;
    logic        req1_ready;
    logic [4:0]  req1_register;
    logic [31:0] req1_data;
    logic [4:0]  write_register;
    logic [31:0] write_data;
    logic        grant_last;

    int checks   = 0;
    int failures = 0;

    // Register file model: commits at the end of the cycle the write is shown.
    logic [31:0] regs [32];

    wb_arbiter #(.DATA_WIDTH(32), .NUM_REGISTERS(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .req0_valid     (req0_valid),
        .req0_ready     (req0_ready),
        .req0_register  (req0_register),
        .req0_data      (req0_data),
        .req1_valid     (req1_valid),
        .req1_ready     (req1_ready),
        .req1_register  (req1_register),
        .req1_data      (req1_data),
        .write_register (write_register),
        .write_data     (write_data),
        .grant_last     (grant_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register 0 is hardwired to zero; other registers take the write.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (write_register != 5'd0) begin
            regs[write_register] <= write_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic exp0;
        rst           = 1'b1;
        req0_valid    = 1'b1;   // valid during reset must not be accepted
        req0_register = 5'd1;
        req0_data     = 32'h1;
        req1_valid    = 1'b0;
        req1_register = 5'd0;
        req1_data     = 32'h0;
        #1;
        check("rst_ready0", 32'(req0_ready), 32'(0));
        check("rst_ready1", 32'(req1_ready), 32'(0));
        step();
        check("rst_wreg", 32'(write_register), 32'(0));
        check("rst_wdata", write_data, 32'h0);
        check("rst_glast", 32'(grant_last), 32'(1));
        rst = 1'b0;
        req0_valid = 1'b0;

        // Both valid in the first cycle after reset, held until accepted.
        req0_valid = 1'b1; req0_register = 5'd3; req0_data = 32'h11;
        req1_valid = 1'b1; req1_register = 5'd4; req1_data = 32'h22;
        #1;
        check("c_ready0", 32'(req0_ready), 32'(!FIXED));
        check("c_ready1", 32'(req1_ready), 32'(FIXED));
        step();
        check("c_wreg1", 32'(write_register), FIXED ? 32'd4 : 32'd3);
        check("c_wdata1", write_data, FIXED ? 32'h22 : 32'h11);
        if (FIXED) req1_valid = 1'b0; else req0_valid = 1'b0;
        #1;
        check("c_ready0b", 32'(req0_ready), 32'(FIXED));
        check("c_ready1b", 32'(req1_ready), 32'(!FIXED));
        step();
        check("c_wreg2", 32'(write_register), FIXED ? 32'd3 : 32'd4);
        check("c_wdata2", write_data, FIXED ? 32'h11 : 32'h22);
        check("c_glast", 32'(grant_last), 32'(!FIXED));
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        check("c_idle_wreg", 32'(write_register), 32'(0));

        // Single source 0 write right after reset.
        do_reset();
        req0_valid = 1'b1; req0_register = 5'd5; req0_data = 32'hDEADBEEF;
        #1;
        check("s_ready0", 32'(req0_ready), 32'(1));
        check("s_ready1", 32'(req1_ready), 32'(0));
        step();
        req0_valid = 1'b0;
        check("s_wreg", 32'(write_register), 32'(5));
        check("s_wdata", write_data, 32'hDEADBEEF);
        check("s_glast", 32'(grant_last), 32'(0));
        step();
        check("s_idle_wreg", 32'(write_register), 32'(0));
        check("s_hold_wdata", write_data, 32'hDEADBEEF);
        check("s_rf5", regs[5], 32'hDEADBEEF);

        // Continuous contention for 8 cycles starting from grant_last = 1.
        do_reset();
        req0_valid = 1'b1; req0_register = 5'd10; req0_data = 32'hA0;
        req1_valid = 1'b1; req1_register = 5'd11; req1_data = 32'hB1;
        for (int i = 0; i < 8; i++) begin
            exp0 = !FIXED && (i % 2 == 0);
            #1;
            check($sformatf("rr_ready0_%0d", i), 32'(req0_ready), 32'(exp0));
            check($sformatf("rr_ready1_%0d", i), 32'(req1_ready), 32'(!exp0));
            @(posedge clk);
            #1;
            check($sformatf("rr_wreg_%0d", i), 32'(write_register), exp0 ? 32'd10 : 32'd11);
            #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();

        // Source 1 writing register 0 is a handshake with no effect.
        req1_valid = 1'b1; req1_register = 5'd0; req1_data = 32'hFFFFFFFF;
        #1;
        check("z_ready1", 32'(req1_ready), 32'(1));
        step();
        req1_valid = 1'b0;
        check("z_wreg", 32'(write_register), 32'(0));
        check("z_glast", 32'(grant_last), 32'(1));
        step();
        check("z_rf0", regs[0], 32'h0);

        // Set grant_last = 0 with a lone source 0 write, then collide on register 7.
        req0_valid = 1'b1; req0_register = 5'd9; req0_data = 32'h9;
        step();
        req0_valid = 1'b0;
        check("w_glast0", 32'(grant_last), 32'(0));
        req0_valid = 1'b1; req0_register = 5'd7; req0_data = 32'hAAAA;
        req1_valid = 1'b1; req1_register = 5'd7; req1_data = 32'h5555;
        #1;
        check("w_ready1", 32'(req1_ready), 32'(1));
        check("w_ready0", 32'(req0_ready), 32'(0));
        step();
        req1_valid = 1'b0;
        check("w_wdata1", write_data, 32'h5555);
        #1;
        check("w_ready0b", 32'(req0_ready), 32'(1));
        step();
        req0_valid = 1'b0;
        check("w_wdata2", write_data, 32'hAAAA);
        step();
        check("w_rf7", regs[7], 32'hAAAA);

        // Reset lands while the contention loser is still waiting.
        req1_valid = 1'b1; req1_register = 5'd12; req1_data = 32'hC;
        step();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_register = 5'd13; req0_data = 32'hD;
        req1_valid = 1'b1; req1_register = 5'd14; req1_data = 32'hE;
        step();
        check("r_wreg_win", 32'(write_register), FIXED ? 32'd14 : 32'd13);
        if (FIXED) req1_valid = 1'b0; else req0_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("r_ready0", 32'(req0_ready), 32'(0));
        check("r_ready1", 32'(req1_ready), 32'(0));
        check("r_wreg_in_rst", 32'(write_register), FIXED ? 32'd14 : 32'd13);
        step();
        rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("r_wreg_post", 32'(write_register), 32'(0));
        check("r_wdata_post", write_data, 32'h0);
        check("r_glast_post", 32'(grant_last), 32'(1));
        step();
        check("r_no_xfer", 32'(write_register), 32'(0));
        if (FIXED) req0_valid = 1'b1; else req1_valid = 1'b1;
        #1;
        check("r_repr_ready", FIXED ? 32'(req0_ready) : 32'(req1_ready), 32'(1));
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("r_repr_wreg", 32'(write_register), FIXED ? 32'd13 : 32'd14);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
